// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for pwm duty sequencers:
// default duty width, FSM state and S-curve phase encodings.
package pwm_ramp_ctrl_pkg;

   localparam int DUTY_W_DEF = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_e;

   typedef enum logic {
      PH_ACCEL = 1'b0,
      PH_DECEL = 1'b1
   } phase_e;

endpackage

// File: rtl/pwm_tick_div.sv
// Ramp tick prescaler: pulses tick every TICK_DIV enabled cycles,
// counter held at zero while en is low.
module pwm_tick_div #(
   parameter int TICK_DIV = 1000
) (
   input  logic Clk,
   input  logic Rst,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LP_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] LP_ONE  = CW'(1);

   logic [CW-1:0] r_cnt;

   assign tick = en && (r_cnt == LP_LAST);

   // count 0..TICK_DIV-1 while enabled, clear otherwise
   always_ff @(posedge Clk) begin
      if (Rst || !en) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + LP_ONE;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty slew sequencer feeding pwm.pwm_in: one step per prescaled tick.
// Optional jerk-limited stepping when PWM_RAMP_SCURVE_EN is defined.
module pwm_ramp_ctrl
   import pwm_ramp_ctrl_pkg::*;
#(
   parameter int DUTY_W   = DUTY_W_DEF,
   parameter int TICK_DIV = 1000
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DUTY_W-1:0] cmd_target,
   input  logic [DUTY_W-1:0] cmd_step,
   input  logic              abort,
   output logic [DUTY_W-1:0] duty_out,
   output logic              busy,
   output logic              done
);

   localparam logic [DUTY_W-1:0] LP_ONE = {{(DUTY_W-1){1'b0}}, 1'b1};

   state_e            r_state;
   state_e            w_state_nxt;
   logic [DUTY_W-1:0] r_duty;
   logic [DUTY_W-1:0] r_target;
   logic [DUTY_W-1:0] r_step;
   logic              r_done;

   logic              w_accept;
   logic              w_tick;
   logic              w_up;
   logic              w_last;
   logic              w_update;
   logic [DUTY_W:0]   w_diff;
   logic [DUTY_W-1:0] w_step_in;
   logic [DUTY_W-1:0] w_step_use;
   logic [DUTY_W-1:0] w_duty_nxt;

   pwm_tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_div (
      .Clk  (Clk),
      .Rst  (Rst),
      .en   (r_state == ST_RAMP),
      .tick (w_tick)
   );

   assign w_accept  = cmd_valid && cmd_ready;
   assign w_step_in = (cmd_step == '0) ? LP_ONE : cmd_step;
   assign w_up      = r_target > r_duty;
   assign w_diff    = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                           : ({1'b0, r_duty} - {1'b0, r_target});
   assign w_last    = w_diff <= {1'b0, w_step_use};
   assign w_update  = (r_state == ST_RAMP) && w_tick && !abort;
   assign w_duty_nxt = w_last ? r_target
                     : (w_up ? r_duty + w_step_use : r_duty - w_step_use);

`ifdef PWM_RAMP_SCURVE_EN
   logic [DUTY_W-1:0] r_cur_step;
   logic [DUTY_W-1:0] r_acc_dist;
   phase_e            r_phase;
   logic [DUTY_W:0]   w_acc_nxt;
   logic [DUTY_W:0]   w_rem;

   // step grows by one while accelerating, shrinks to one while braking
   always_comb begin
      w_step_use = r_step;
      if (r_phase == PH_ACCEL) begin
         w_step_use = (r_cur_step < r_step) ? r_cur_step + LP_ONE : r_step;
      end else begin
         w_step_use = (r_cur_step > LP_ONE) ? r_cur_step - LP_ONE : LP_ONE;
      end
   end

   assign w_acc_nxt = {1'b0, r_acc_dist} + {1'b0, w_step_use};
   assign w_rem     = w_diff - {1'b0, w_step_use};

   // S-curve state: brake once remaining distance fits the accel distance
   always_ff @(posedge Clk) begin
      if (Rst || w_accept) begin
         r_cur_step <= '0;
         r_acc_dist <= '0;
         r_phase    <= PH_ACCEL;
      end else if (w_update) begin
         r_cur_step <= w_step_use;
         if (r_phase == PH_ACCEL) begin
            r_acc_dist <= w_acc_nxt[DUTY_W-1:0];
            if (w_rem <= w_acc_nxt) begin
               r_phase <= PH_DECEL;
            end
         end
      end
   end
`else
   assign w_step_use = r_step;
`endif

   // state register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state: abort beats a coincident tick
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept && (cmd_target != r_duty)) begin
               w_state_nxt = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_tick && w_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      cmd_ready = (r_state == ST_IDLE);
      busy      = (r_state == ST_RAMP);
   end

   // command latch, duty register and done pulse
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_duty   <= '0;
         r_target <= '0;
         r_step   <= LP_ONE;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_target <= cmd_target;
            r_step   <= w_step_in;
            if (cmd_target == r_duty) begin
               r_done <= 1'b1;
            end
         end else if (w_update) begin
            r_duty <= w_duty_nxt;
            if (w_last) begin
               r_done <= 1'b1;
            end
         end
      end
   end

   assign duty_out = r_duty;
   assign done     = r_done;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with TICK_DIV=4.
// Define PWM_RAMP_SCURVE_EN to exercise the S-curve build.
module tb_pwm_ramp_ctrl;

   logic        Clk;
   logic        Rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_target;
   logic [15:0] cmd_step;
   logic        abort;
   logic [15:0] duty_out;
   logic        busy;
   logic        done;

   int n_chk;
   int n_fail;

   pwm_ramp_ctrl #(
      .DUTY_W   (16),
      .TICK_DIV (4)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_target (cmd_target),
      .cmd_step   (cmd_step),
      .abort      (abort),
      .duty_out   (duty_out),
      .busy       (busy),
      .done       (done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // offer a command for one cycle starting at a negedge
   task automatic send(input logic [15:0] tgt, input logic [15:0] stp);
      cmd_target = tgt;
      cmd_step   = stp;
      cmd_valid  = 1'b1;
      chk("rdy_offer", {31'd0, cmd_ready}, 32'd1);
      @(negedge Clk);
      cmd_valid = 1'b0;
   endtask

   // one ramp tick: duty holds 3 cycles, then steps
   task automatic expect_tick(input logic [15:0] prev,
                              input logic [15:0] exp,
                              input logic last);
      repeat (3) @(negedge Clk);
      chk("hold", {16'd0, duty_out}, {16'd0, prev});
      chk("busy_mid", {31'd0, busy}, 32'd1);
      chk("rdy_mid", {31'd0, cmd_ready}, 32'd0);
      chk("done_mid", {31'd0, done}, 32'd0);
      @(negedge Clk);
      chk("duty", {16'd0, duty_out}, {16'd0, exp});
      chk("done", {31'd0, done}, {31'd0, last});
      chk("busy", {31'd0, busy}, {31'd0, !last});
   endtask

   task automatic same_target(input logic [15:0] v);
      send(v, 16'd5);
      chk("same_done", {31'd0, done}, 32'd1);
      chk("same_busy", {31'd0, busy}, 32'd0);
      chk("same_duty", {16'd0, duty_out}, {16'd0, v});
      chk("same_rdy", {31'd0, cmd_ready}, 32'd1);
      @(negedge Clk);
      chk("same_done_clr", {31'd0, done}, 32'd0);
      chk("same_busy2", {31'd0, busy}, 32'd0);
   endtask

`ifdef PWM_RAMP_SCURVE_EN
   logic [15:0] sc [11] = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd13, 16'd15,
                            16'd16, 16'd17, 16'd18, 16'd19, 16'd20};
`else
   logic [15:0] t2 [4] = '{16'd30, 16'd60, 16'd90, 16'd100};
   logic [15:0] t3 [3] = '{16'd99, 16'd98, 16'd97};
`endif

   initial begin
      #100000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1);
   end

   initial begin
      logic [15:0] prev;
      n_chk      = 0;
      n_fail     = 0;
      Rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_target = '0;
      cmd_step   = '0;
      abort      = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_duty", {16'd0, duty_out}, 32'd0);
      chk("rst_rdy", {31'd0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      Rst = 1'b0;
      @(negedge Clk);

`ifdef PWM_RAMP_SCURVE_EN
      send(16'd20, 16'd4);
      prev = 16'd0;
      for (int i = 0; i < 11; i++) begin
         expect_tick(prev, sc[i], i == 10);
         prev = sc[i];
      end
      @(negedge Clk);
      chk("sc_done_clr", {31'd0, done}, 32'd0);
      same_target(16'd20);
`else
      send(16'd100, 16'd30);
      prev = 16'd0;
      for (int i = 0; i < 4; i++) begin
         expect_tick(prev, t2[i], i == 3);
         prev = t2[i];
      end
      chk("t2_rdy_end", {31'd0, cmd_ready}, 32'd1);
      @(negedge Clk);
      chk("t2_done_clr", {31'd0, done}, 32'd0);

      send(16'd97, 16'd0);
      prev = 16'd100;
      for (int i = 0; i < 3; i++) begin
         expect_tick(prev, t3[i], i == 2);
         prev = t3[i];
      end
      @(negedge Clk);
      chk("t3_done_clr", {31'd0, done}, 32'd0);
      chk("t3_duty", {16'd0, duty_out}, 32'd97);

      send(16'd1000, 16'd10);
      expect_tick(16'd97, 16'd107, 1'b0);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      chk("rst_mid_duty", {16'd0, duty_out}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_rdy", {31'd0, cmd_ready}, 32'd1);

      send(16'd1000, 16'd10);
      expect_tick(16'd0, 16'd10, 1'b0);
      expect_tick(16'd10, 16'd20, 1'b0);
      expect_tick(16'd20, 16'd30, 1'b0);
      abort = 1'b1;
      @(negedge Clk);
      abort = 1'b0;
      chk("abort_duty", {16'd0, duty_out}, 32'd30);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_rdy", {31'd0, cmd_ready}, 32'd1);
      repeat (6) @(negedge Clk);
      chk("abort_hold", {16'd0, duty_out}, 32'd30);

      send(16'd1000, 16'd10);
      repeat (3) @(negedge Clk);
      abort = 1'b1;
      @(negedge Clk);
      abort = 1'b0;
      chk("abtick_duty", {16'd0, duty_out}, 32'd30);
      chk("abtick_busy", {31'd0, busy}, 32'd0);
      chk("abtick_done", {31'd0, done}, 32'd0);

      abort = 1'b1;
      send(16'd40, 16'd10);
      abort = 1'b0;
      chk("idle_abort_busy", {31'd0, busy}, 32'd1);
      expect_tick(16'd30, 16'd40, 1'b1);
      @(negedge Clk);

      same_target(16'd40);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
